mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter LS_BURST_MAX, default 4: maximum consecutive load/store grants while a fetch request waits.
REQ-002 Parameter XLEN, default 32: address and data width.
REQ-003 m_clock  in  1  clock; all state updates on rising edge.
REQ-004 p_reset  in  1  reset, asynchronous, active-high.
REQ-005 if_req_valid_i  in  1  fetch read request valid.
REQ-006 if_req_ready_o  out  1  fetch request accepted this cycle.
REQ-007 if_addr_i  in  XLEN  fetch byte address (pc).
REQ-008 if_flush_i  in  1  branch redirect; kills fetch traffic.
REQ-009 if_rsp_valid_o  out  1  fetch response valid.
REQ-010 if_rsp_ready_i  in  1  fetch consumer ready.
REQ-011 if_rsp_data_o / if_rsp_addr_o  out  XLEN each  instruction word and its address.
REQ-012 ls_req_valid_i  in  1  load/store request valid.
REQ-013 ls_req_ready_o  out  1  load/store request accepted this cycle.
REQ-014 ls_addr_i  in  XLEN; ls_we_i  in  1; ls_wdata_i  in  XLEN; ls_be_i  in  4  load/store address, write enable, write data, byte enables.
REQ-015 ls_rsp_valid_o  out  1; ls_rsp_ready_i  in  1; ls_rsp_data_o  out  XLEN  load response handshake and data.
REQ-016 mem_en_o, mem_we_o  out  1; mem_be_o  out  4; mem_addr_o, mem_wdata_o  out  XLEN  shared single-port sync memory.
REQ-017 mem_rdata_i  in  XLEN  read data, valid exactly one cycle after the mem_en_o cycle.

Function
REQ-018 Request transfer when valid and ready are both 1 in the same cycle; the winning request drives mem_* combinationally that cycle (mem_en_o=1).
REQ-019 At most one outstanding read at any time.
REQ-020 FSM states: IDLE (no read outstanding), RESP (read issued last cycle; response driven from mem_rdata_i), HOLD (response held in a register).
REQ-021 IDLE: grant allowed; read grant -> RESP; write grant -> stays IDLE; no grant -> IDLE.
REQ-022 RESP: owner's rsp_valid_o=1 with data=mem_rdata_i; rsp_ready=1 -> a new grant is allowed the same cycle (next state RESP after a read grant, IDLE otherwise); rsp_ready=0 -> capture mem_rdata_i into the hold register, go to HOLD, no grant.
REQ-023 HOLD: rsp_valid_o=1 from the hold register; no grant; rsp_ready=1 -> IDLE.
REQ-024 Arbitration: load/store wins over fetch, unless the streak counter equals LS_BURST_MAX, in which case fetch wins.
REQ-025 Streak counter: increment on each load/store grant while if_req_valid_i=1; clear on fetch grant or whenever if_req_valid_i=0; saturate at LS_BURST_MAX.
REQ-026 Writes produce no response; a write grant completes in its issue cycle, with mem_we_o=1 and mem_be_o=ls_be_i.
REQ-027 if_flush_i=1 forces if_req_ready_o=0 that cycle.
REQ-028 if_flush_i=1 while a fetch response is in RESP or HOLD: if_rsp_valid_o=0 that cycle, response discarded, next state IDLE, and a new grant is allowed.
REQ-029 if_flush_i=1 has no effect on a load/store response.
REQ-030 if_rsp_addr_o equals the address latched at grant.
REQ-031 Peak throughput: one read per cycle when the consumer's rsp_ready is held at 1.
REQ-032 The non-owner rsp_valid_o is always 0; inactive mem_* outputs drive 0.

Reset
REQ-033 On p_reset=1, immediately and asynchronously: state=IDLE, streak=0, owner=fetch, hold/address registers=0, all rsp_valid_o=0.
REQ-034 Reset asserted mid-operation shall drop any outstanding response without delivering it.
REQ-035 Ready outputs shall be 0 while p_reset=1.

Structure
REQ-036 Shared package contains: XLEN, the state enum {IDLE,RESP,HOLD}, and the owner enum {OWN_IF,OWN_LS}.
REQ-037 One sub-module, mem_rsp_hold: the response capture/hold register with valid flag.

Verification
REQ-038 Fetch-only stream, addr 0,4,8, rsp_ready=1 -> mem_en_o on 3 consecutive cycles; responses one cycle later carry rom[0], rom[1], rom[2] with matching addresses.
REQ-039 Both requesters valid continuously, LS_BURST_MAX=4 -> grant order LS,LS,LS,LS,IF, repeating.
REQ-040 Fetch read at addr 40 with if_rsp_ready_i=0 for 2 cycles -> HOLD entered; data rom[10] stable; delivered once when ready rises; no grant meanwhile.
REQ-041 if_flush_i pulsed the cycle after a fetch grant -> no if_rsp_valid_o; a new fetch at addr 40 is granted the same cycle flush deasserts.
REQ-042 Load/store write (addr 0x100, be=0xF, data 0xDEADBEEF) followed by a read of 0x100 -> no response for the write; read returns 0xDEADBEEF after 1 cycle.
REQ-043 p_reset asserted while in HOLD -> all outputs 0 immediately; after release, the first request is granted from IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch / load-store memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE,
        RESP,
        HOLD
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_LS
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response/memory signal bundle; slave = arbiter side, master = core + memory side.
interface mem_port_arbiter_if #(
    parameter int XLEN = mem_port_arbiter_pkg::XLEN
);
    logic            if_req_valid_i;
    logic            if_req_ready_o;
    logic [XLEN-1:0] if_addr_i;
    logic            if_flush_i;
    logic            if_rsp_valid_o;
    logic            if_rsp_ready_i;
    logic [XLEN-1:0] if_rsp_data_o;
    logic [XLEN-1:0] if_rsp_addr_o;

    logic            ls_req_valid_i;
    logic            ls_req_ready_o;
    logic [XLEN-1:0] ls_addr_i;
    logic            ls_we_i;
    logic [XLEN-1:0] ls_wdata_i;
    logic [3:0]      ls_be_i;
    logic            ls_rsp_valid_o;
    logic            ls_rsp_ready_i;
    logic [XLEN-1:0] ls_rsp_data_o;

    logic            mem_en_o;
    logic            mem_we_o;
    logic [3:0]      mem_be_o;
    logic [XLEN-1:0] mem_addr_o;
    logic [XLEN-1:0] mem_wdata_o;
    logic [XLEN-1:0] mem_rdata_i;

    modport slave (
        input  if_req_valid_i, if_addr_i, if_flush_i, if_rsp_ready_i,
        input  ls_req_valid_i, ls_addr_i, ls_we_i, ls_wdata_i, ls_be_i, ls_rsp_ready_i,
        input  mem_rdata_i,
        output if_req_ready_o, if_rsp_valid_o, if_rsp_data_o, if_rsp_addr_o,
        output ls_req_ready_o, ls_rsp_valid_o, ls_rsp_data_o,
        output mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output if_req_valid_i, if_addr_i, if_flush_i, if_rsp_ready_i,
        output ls_req_valid_i, ls_addr_i, ls_we_i, ls_wdata_i, ls_be_i, ls_rsp_ready_i,
        output mem_rdata_i,
        input  if_req_ready_o, if_rsp_valid_o, if_rsp_data_o, if_rsp_addr_o,
        input  ls_req_ready_o, ls_rsp_valid_o, ls_rsp_data_o,
        input  mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
    );

endinterface

// File: rtl/mem_port_arbiter_hold.sv
// Parks a read word when its consumer stalls; capture wins over clear.
// One-cycle capture latency; the held word stays stable until cleared.
module mem_rsp_hold
    import mem_port_arbiter_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic         m_clock,
    input  logic         p_reset,
    input  logic         capture,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         vld
);

    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            dout <= '0;
            vld  <= 1'b0;
        end else if (capture) begin
            dout <= din;
            vld  <= 1'b1;
        end else if (clear) begin
            vld  <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port sync memory between fetch and load/store; one read in flight.
// Grants drive mem_* in the accept cycle, read data returns next cycle; a stalled response is held and blocks grants.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int LS_BURST_MAX = 4,
    parameter int XLEN         = mem_port_arbiter_pkg::XLEN
) (
    input  logic                m_clock,
    input  logic                p_reset,
    mem_port_arbiter_if.slave   bus
);

    localparam int SW = $clog2(LS_BURST_MAX + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(LS_BURST_MAX);

    state_t          state;
    owner_t          owner;
    logic [SW-1:0]   streak;
    logic [XLEN-1:0] if_addr_q;

    logic            resp_active;
    logic            owner_rdy;
    logic            if_kill;
    logic            grant_ok;
    logic            if_can;
    logic            ls_win;
    logic            if_gnt;
    logic            ls_gnt;
    logic            rd_gnt;
    logic            capture;
    logic            clear;
    logic [XLEN-1:0] hold_dat;
    logic            hold_vld;
    logic [XLEN-1:0] rsp_dat;

    assign resp_active = (state != IDLE);
    assign owner_rdy   = (owner == OWN_IF) ? bus.if_rsp_ready_i : bus.ls_rsp_ready_i;
    // A flushed fetch response frees the port exactly like a consumed one.
    assign if_kill     = resp_active && (owner == OWN_IF) && bus.if_flush_i;

    always_comb begin
        grant_ok = 1'b0;
        unique case (state)
            IDLE:    grant_ok = 1'b1;
            RESP:    grant_ok = owner_rdy || if_kill;
            HOLD:    grant_ok = if_kill;
            default: grant_ok = 1'b0;
        endcase
        grant_ok = grant_ok && !p_reset;
    end

    // Fetch only beats load/store once the streak has saturated.
    assign if_can = bus.if_req_valid_i && !bus.if_flush_i;
    assign ls_win = bus.ls_req_valid_i && !(if_can && (streak == STREAK_MAX));
    assign ls_gnt = grant_ok && ls_win;
    assign if_gnt = grant_ok && if_can && !ls_win;
    assign rd_gnt = if_gnt || (ls_gnt && !bus.ls_we_i);

    assign bus.if_req_ready_o = if_gnt;
    assign bus.ls_req_ready_o = ls_gnt;

    always_comb begin
        bus.mem_en_o    = 1'b0;
        bus.mem_we_o    = 1'b0;
        bus.mem_be_o    = 4'h0;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        if (ls_gnt) begin
            bus.mem_en_o    = 1'b1;
            bus.mem_we_o    = bus.ls_we_i;
            bus.mem_be_o    = bus.ls_be_i;
            bus.mem_addr_o  = bus.ls_addr_i;
            bus.mem_wdata_o = bus.ls_wdata_i;
        end else if (if_gnt) begin
            bus.mem_en_o    = 1'b1;
            bus.mem_be_o    = 4'hF;
            bus.mem_addr_o  = bus.if_addr_i;
        end
    end

    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            state     <= IDLE;
            owner     <= OWN_IF;
            streak    <= '0;
            if_addr_q <= '0;
        end else begin
            if (if_gnt)
                if_addr_q <= bus.if_addr_i;
            if (rd_gnt)
                owner <= if_gnt ? OWN_IF : OWN_LS;

            if (!bus.if_req_valid_i || if_gnt)
                streak <= '0;
            else if (ls_gnt && (streak != STREAK_MAX))
                streak <= streak + 1'b1;

            unique case (state)
                IDLE: state <= rd_gnt ? RESP : IDLE;
                RESP: begin
                    if (grant_ok)
                        state <= rd_gnt ? RESP : IDLE;
                    else
                        state <= HOLD;
                end
                HOLD: begin
                    if (if_kill)
                        state <= rd_gnt ? RESP : IDLE;
                    else if (owner_rdy)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign capture = (state == RESP) && !owner_rdy && !if_kill;
    assign clear   = (state == HOLD) && (owner_rdy || if_kill);

    mem_rsp_hold #(
        .W (XLEN)
    ) u_hold (
        .m_clock (m_clock),
        .p_reset (p_reset),
        .capture (capture),
        .clear   (clear),
        .din     (bus.mem_rdata_i),
        .dout    (hold_dat),
        .vld     (hold_vld)
    );

    assign rsp_dat = hold_vld ? hold_dat : bus.mem_rdata_i;

    assign bus.if_rsp_valid_o = resp_active && (owner == OWN_IF) && !bus.if_flush_i;
    assign bus.ls_rsp_valid_o = resp_active && (owner == OWN_LS);
    assign bus.if_rsp_data_o  = bus.if_rsp_valid_o ? rsp_dat : '0;
    assign bus.ls_rsp_data_o  = bus.ls_rsp_valid_o ? rsp_dat : '0;
    assign bus.if_rsp_addr_o  = if_addr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural sync RAM (word i reads 0x1000_0000|i until written).
module tb_mem_port_arbiter;

    logic m_clock;
    logic p_reset;
    int   n_chk = 0;
    int   n_err = 0;

    mem_port_arbiter_if #(.XLEN(32)) bus ();

    mem_port_arbiter #(
        .LS_BURST_MAX (4),
        .XLEN         (32)
    ) dut (
        .m_clock (m_clock),
        .p_reset (p_reset),
        .bus     (bus)
    );

    initial begin
        m_clock = 1'b0;
        forever #5 m_clock = ~m_clock;
    end

    logic [31:0]  wmem [0:127];
    logic [127:0] wr_vld = '0;
    wire  [6:0]   ma = bus.mem_addr_o[8:2];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    always @(posedge m_clock) begin
        if (bus.mem_en_o) begin
            if (bus.mem_we_o) begin
                wmem[ma]   <= merge(wr_vld[ma] ? wmem[ma] : (32'h1000_0000 | 32'(ma)),
                                    bus.mem_wdata_o, bus.mem_be_o);
                wr_vld[ma] <= 1'b1;
            end else begin
                bus.mem_rdata_i <= wr_vld[ma] ? wmem[ma] : (32'h1000_0000 | 32'(ma));
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge m_clock);
        #1;
    endtask

    task automatic settle();
        @(negedge m_clock);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        p_reset            = 1'b1;
        bus.if_req_valid_i = 1'b1;
        bus.if_addr_i      = '0;
        bus.if_flush_i     = 1'b0;
        bus.if_rsp_ready_i = 1'b1;
        bus.ls_req_valid_i = 1'b1;
        bus.ls_addr_i      = '0;
        bus.ls_we_i        = 1'b0;
        bus.ls_wdata_i     = '0;
        bus.ls_be_i        = 4'hF;
        bus.ls_rsp_ready_i = 1'b1;

        // reset: readies, valids and memory enable all low
        #2;
        chk("rst_rdy",  {30'd0, bus.if_req_ready_o, bus.ls_req_ready_o}, 32'h0);
        chk("rst_rsp",  {30'd0, bus.if_rsp_valid_o, bus.ls_rsp_valid_o}, 32'h0);
        chk("rst_mem",  {31'd0, bus.mem_en_o}, 32'h0);
        chk("rst_addr", bus.if_rsp_addr_o, 32'h0);
        bus.if_req_valid_i = 1'b0;
        bus.ls_req_valid_i = 1'b0;
        tick();
        tick();
        p_reset = 1'b0;

        // fetch stream 0,4,8 back to back
        bus.if_req_valid_i = 1'b1;
        bus.if_addr_i      = 32'd0;
        settle();
        chk("f0_en",   {31'd0, bus.mem_en_o}, 32'h1);
        chk("f0_addr", bus.mem_addr_o, 32'd0);
        tick();
        bus.if_addr_i = 32'd4;
        settle();
        chk("f1_en",   {31'd0, bus.mem_en_o}, 32'h1);
        chk("f1_addr", bus.mem_addr_o, 32'd4);
        chk("r0_vld",  {31'd0, bus.if_rsp_valid_o}, 32'h1);
        chk("r0_dat",  bus.if_rsp_data_o, 32'h1000_0000);
        chk("r0_addr", bus.if_rsp_addr_o, 32'd0);
        tick();
        bus.if_addr_i = 32'd8;
        settle();
        chk("f2_en",   {31'd0, bus.mem_en_o}, 32'h1);
        chk("r1_dat",  bus.if_rsp_data_o, 32'h1000_0001);
        chk("r1_addr", bus.if_rsp_addr_o, 32'd4);
        tick();
        bus.if_req_valid_i = 1'b0;
        settle();
        chk("f3_en",   {31'd0, bus.mem_en_o}, 32'h0);
        chk("r2_dat",  bus.if_rsp_data_o, 32'h1000_0002);
        chk("r2_addr", bus.if_rsp_addr_o, 32'd8);
        tick();

        // both requesters busy: LS,LS,LS,LS,IF repeating; obs = {if_rdy, ls_rdy, if_rsp, ls_rsp}
        bus.if_req_valid_i = 1'b1;
        bus.if_addr_i      = 32'd12;
        bus.ls_req_valid_i = 1'b1;
        bus.ls_we_i        = 1'b0;
        bus.ls_addr_i      = 32'h20;
        for (int i = 0; i < 10; i++) begin
            logic [1:0] g_exp, r_exp;
            g_exp = (i % 5 == 4) ? 2'b10 : 2'b01;
            r_exp = (i == 0) ? 2'b00 : (((i - 1) % 5 == 4) ? 2'b10 : 2'b01);
            settle();
            chk($sformatf("arb%0d", i),
                {28'd0, bus.if_req_ready_o, bus.ls_req_ready_o, bus.if_rsp_valid_o, bus.ls_rsp_valid_o},
                {28'd0, g_exp, r_exp});
            tick();
        end
        bus.if_req_valid_i = 1'b0;
        bus.ls_req_valid_i = 1'b0;
        settle();
        chk("arb_tail",
            {28'd0, bus.if_req_ready_o, bus.ls_req_ready_o, bus.if_rsp_valid_o, bus.ls_rsp_valid_o},
            32'b0010);
        tick();

        // fetch at 40 stalls two cycles; pending load must wait
        bus.if_req_valid_i = 1'b1;
        bus.if_addr_i      = 32'd40;
        bus.if_rsp_ready_i = 1'b0;
        settle();
        chk("h_gnt", {31'd0, bus.if_req_ready_o}, 32'h1);
        tick();
        bus.if_req_valid_i = 1'b0;
        bus.ls_req_valid_i = 1'b1;
        bus.ls_addr_i      = 32'h0;
        settle();
        chk("h_resp_vld", {31'd0, bus.if_rsp_valid_o}, 32'h1);
        chk("h_resp_dat", bus.if_rsp_data_o, 32'h1000_000A);
        chk("h_resp_blk", {31'd0, bus.ls_req_ready_o}, 32'h0);
        tick();
        settle();
        chk("h_hold_dat", bus.if_rsp_data_o, 32'h1000_000A);
        chk("h_hold_blk", {30'd0, bus.ls_req_ready_o, bus.mem_en_o}, 32'h0);
        tick();
        bus.if_rsp_ready_i = 1'b1;
        settle();
        chk("h_dlv_vld",  {31'd0, bus.if_rsp_valid_o}, 32'h1);
        chk("h_dlv_dat",  bus.if_rsp_data_o, 32'h1000_000A);
        chk("h_dlv_addr", bus.if_rsp_addr_o, 32'd40);
        chk("h_dlv_blk",  {31'd0, bus.ls_req_ready_o}, 32'h0);
        tick();
        settle();
        chk("h_once",   {31'd0, bus.if_rsp_valid_o}, 32'h0);
        chk("h_ls_gnt", {31'd0, bus.ls_req_ready_o}, 32'h1);
        tick();
        bus.ls_req_valid_i = 1'b0;
        settle();
        chk("h_ls_rsp", {31'd0, bus.ls_rsp_valid_o}, 32'h1);
        chk("h_ls_dat", bus.ls_rsp_data_o, 32'h1000_0000);
        tick();

        // flush the cycle after a fetch grant
        bus.if_req_valid_i = 1'b1;
        bus.if_addr_i      = 32'd8;
        settle();
        chk("fl_gnt", {31'd0, bus.if_req_ready_o}, 32'h1);
        tick();
        bus.if_flush_i = 1'b1;
        bus.if_addr_i  = 32'd40;
        settle();
        chk("fl_rsp", {31'd0, bus.if_rsp_valid_o}, 32'h0);
        chk("fl_rdy", {31'd0, bus.if_req_ready_o}, 32'h0);
        tick();
        bus.if_flush_i = 1'b0;
        settle();
        chk("fl_regnt", {31'd0, bus.if_req_ready_o}, 32'h1);
        chk("fl_addr",  bus.mem_addr_o, 32'd40);
        chk("fl_stale", {31'd0, bus.if_rsp_valid_o}, 32'h0);
        tick();
        bus.if_req_valid_i = 1'b0;
        settle();
        chk("fl_new_dat",  bus.if_rsp_data_o, 32'h1000_000A);
        chk("fl_new_addr", bus.if_rsp_addr_o, 32'd40);
        tick();

        // write then read back 0x100
        bus.ls_req_valid_i = 1'b1;
        bus.ls_we_i        = 1'b1;
        bus.ls_addr_i      = 32'h100;
        bus.ls_be_i        = 4'hF;
        bus.ls_wdata_i     = 32'hDEAD_BEEF;
        settle();
        chk("w_ctl",   {29'd0, bus.ls_req_ready_o, bus.mem_en_o, bus.mem_we_o}, 32'b111);
        chk("w_be",    {28'd0, bus.mem_be_o}, 32'hF);
        chk("w_wdata", bus.mem_wdata_o, 32'hDEAD_BEEF);
        tick();
        bus.ls_we_i = 1'b0;
        settle();
        chk("w_norsp", {31'd0, bus.ls_rsp_valid_o}, 32'h0);
        chk("rd_ctl",  {29'd0, bus.ls_req_ready_o, bus.mem_en_o, bus.mem_we_o}, 32'b110);
        tick();
        bus.ls_req_valid_i = 1'b0;
        settle();
        chk("rd_vld", {31'd0, bus.ls_rsp_valid_o}, 32'h1);
        chk("rd_dat", bus.ls_rsp_data_o, 32'hDEAD_BEEF);
        tick();

        // reset while holding a fetch response
        bus.if_req_valid_i = 1'b1;
        bus.if_addr_i      = 32'd4;
        bus.if_rsp_ready_i = 1'b0;
        tick();
        bus.if_req_valid_i = 1'b0;
        tick();
        settle();
        chk("rh_hold", bus.if_rsp_data_o, 32'h1000_0001);
        p_reset            = 1'b1;
        bus.ls_req_valid_i = 1'b1;
        bus.ls_addr_i      = 32'h8;
        #1;
        chk("rh_vld",  {30'd0, bus.if_rsp_valid_o, bus.ls_rsp_valid_o}, 32'h0);
        chk("rh_dat",  bus.if_rsp_data_o, 32'h0);
        chk("rh_addr", bus.if_rsp_addr_o, 32'h0);
        chk("rh_rdy",  {29'd0, bus.if_req_ready_o, bus.ls_req_ready_o, bus.mem_en_o}, 32'h0);
        tick();
        p_reset            = 1'b0;
        bus.if_rsp_ready_i = 1'b1;
        settle();
        chk("ra_gnt",  {31'd0, bus.ls_req_ready_o}, 32'h1);
        chk("ra_drop", {31'd0, bus.if_rsp_valid_o}, 32'h0);
        tick();
        bus.ls_req_valid_i = 1'b0;
        settle();
        chk("ra_rsp", {30'd0, bus.if_rsp_valid_o, bus.ls_rsp_valid_o}, 32'b01);
        chk("ra_dat", bus.ls_rsp_data_o, 32'h1000_0002);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
